// File: rtl/debounce_pkg.sv
// debounce_pkg: shared defaults, counter sizing helper and state encoding for debounce_sync.
package debounce_pkg;
    localparam int DEFAULT_SYNC_STAGES   = 2;
    localparam int DEFAULT_STABLE_CYCLES = 10;

    typedef enum logic {IDLE, QUALIFY} state_t;

    // Smallest counter width able to hold 0..stable_cycles-1.
    function automatic int cnt_width(input int stable_cycles);
        return (stable_cycles > 1) ? $clog2(stable_cycles) : 1;
    endfunction
endpackage

// File: rtl/debounce_sync_sync_chain.sv
// sync_chain: N-stage flop chain bringing an asynchronous level into the clk domain.
module sync_chain #(
    parameter int   N         = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [N-1:0] r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r <= {N{RESET_VAL}};
        else     r <= {r[N-2:0], d};
    end

    assign q = r[N-1];
endmodule

// File: rtl/debounce_sync.sv
// debounce_sync: synchronise and debounce a raw level into dout with rise/fall pulses.
// Optional DEBOUNCE_TOGGLE_EN adds a toggle output that flips on every rise pulse.
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter int   CNT_W         = 4,
    parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
`ifdef DEBOUNCE_TOGGLE_EN
    ,
    output logic toggle
`endif
);
    if (SYNC_STAGES < 2 || STABLE_CYCLES < 1 || CNT_W < cnt_width(STABLE_CYCLES)) begin : g_bad_params
        $error("debounce_sync: illegal SYNC_STAGES/STABLE_CYCLES/CNT_W combination");
    end

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s;
    logic             done;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    state_t           state;

    sync_chain #(.N(SYNC_STAGES), .RESET_VAL(RESET_VAL)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (s)
    );

    // A matching sample aborts qualification; reaching LAST commits the change.
    always_comb begin
        done    = (s != dout) && (cnt == LAST);
        cnt_nxt = (s == dout || done) ? '0 : cnt + 1'b1;
        state   = (cnt != '0) ? QUALIFY : IDLE;
        busy    = (state == QUALIFY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            dout <= RESET_VAL;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            dout <= done ? s : dout;
            rise <= done & s;
            fall <= done & ~s;
        end
    end

`ifdef DEBOUNCE_TOGGLE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) toggle <= 1'b0;
        else     toggle <= toggle ^ (done & s);
    end
`endif
endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync: directed scenarios plus randomized din against a sample-window reference model.
module tb_debounce_sync;
    localparam int   SS = 2;
    localparam int   SC = 4;
    localparam logic RV = 1'b0;

    logic clk = 1'b0;
    logic rst;
    logic din = 1'b0;
    logic dout, rise, fall, busy;
`ifdef DEBOUNCE_TOGGLE_EN
    logic toggle;
    bit   m_toggle;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;

    debounce_sync #(.SYNC_STAGES(SS), .CNT_W(4), .STABLE_CYCLES(SC), .RESET_VAL(RV)) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .dout (dout),
        .rise (rise),
        .fall (fall),
        .busy (busy)
`ifdef DEBOUNCE_TOGGLE_EN
        ,
        .toggle (toggle)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: dq is the din delay through the synchroniser, sv the
    // synchronised samples since the last reset or dout change. dout flips when
    // the most recent SC samples all disagree with it.
    bit dq[$];
    bit sv[$];
    bit m_dout, m_rise, m_fall, m_busy;

    task automatic m_reset();
        dq.delete();
        repeat (SS) dq.push_back(RV);
        sv.delete();
        m_dout = RV;
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_busy = 1'b0;
`ifdef DEBOUNCE_TOGGLE_EN
        m_toggle = 1'b0;
`endif
    endtask

    initial begin
        bit s_v;
        bit all_diff;
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else begin
                s_v = dq.pop_front();
                dq.push_back(din);
                sv.push_back(s_v);
                m_rise = 1'b0;
                m_fall = 1'b0;
                all_diff = (sv.size() >= SC);
                for (int i = 1; i <= SC && all_diff; i++)
                    if (sv[sv.size() - i] == m_dout) all_diff = 1'b0;
                if (all_diff) begin
                    m_dout = s_v;
                    m_rise = s_v;
                    m_fall = !s_v;
                    sv.delete();
`ifdef DEBOUNCE_TOGGLE_EN
                    m_toggle = m_toggle ^ s_v;
`endif
                end
                m_busy = (sv.size() > 0) && (sv[sv.size() - 1] != m_dout);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("dout", dout, m_dout);
            chk("rise", rise, m_rise);
            chk("fall", fall, m_fall);
            chk("busy", busy, m_busy);
            chk("rise_fall_excl", rise & fall, 1'b0);
`ifdef DEBOUNCE_TOGGLE_EN
            chk("toggle", toggle, m_toggle);
`endif
            if (rise) rise_cnt++;
            if (fall) fall_cnt++;
        end
    end

    initial begin
        int hold;
        rst = 1'b1;
        din = 1'b1;
        #1;
        chk("reset_dout_async", dout, 1'b0);
        chk("reset_rise_async", rise, 1'b0);
        chk("reset_fall_async", fall, 1'b0);
        chk("reset_busy_async", busy, 1'b0);
        tick(5);
        chk("reset_hold_dout", dout, 1'b0);
        rst = 1'b0;
        din = 1'b0;
        tick(3);

        // Glitch shorter than the qualification window
        rise_cnt = 0;
        din = 1'b1;
        tick(3);
        din = 1'b0;
        tick(10);
        chk("glitch_dout", dout, 1'b0);
        chk("glitch_no_rise", rise_cnt == 0, 1'b1);

        // Clean rise: change lands on the 6th edge after din moves
        din = 1'b1;
        tick(2);
        chk("rise_busy_e2", busy, 1'b0);
        tick(1);
        chk("rise_busy_e3", busy, 1'b1);
        tick(2);
        chk("rise_dout_e5", dout, 1'b0);
        chk("rise_busy_e5", busy, 1'b1);
        tick(1);
        chk("rise_dout_e6", dout, 1'b1);
        chk("rise_pulse_e6", rise, 1'b1);
        chk("rise_nofall_e6", fall, 1'b0);
        chk("rise_busy_e6", busy, 1'b0);
        chk("model_dout_e6", m_dout, 1'b1);
        tick(1);
        chk("rise_pulse_e7", rise, 1'b0);

        // Clean fall
        din = 1'b0;
        tick(5);
        chk("fall_dout_e5", dout, 1'b1);
        tick(1);
        chk("fall_dout_e6", dout, 1'b0);
        chk("fall_pulse_e6", fall, 1'b1);
        chk("model_fall_e6", m_fall, 1'b1);
        tick(1);
        chk("fall_pulse_e7", fall, 1'b0);

        // Bounce then settle high
        rise_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            din = ~din;
            tick(1);
        end
        din = 1'b1;
        tick(5);
        chk("bounce_dout_e5", dout, 1'b0);
        tick(1);
        chk("bounce_dout_e6", dout, 1'b1);
        chk("bounce_rise_e6", rise, 1'b1);
        tick(3);
        chk("bounce_one_rise", rise_cnt == 1, 1'b1);

        // Fall interrupted by reset at cnt=2
        fall_cnt = 0;
        din = 1'b0;
        tick(4);
        chk("midrst_busy", busy, 1'b1);
        chk("midrst_dout_before", dout, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_dout_async", dout, 1'b0);
        chk("midrst_busy_async", busy, 1'b0);
        chk("midrst_fall_async", fall, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick(10);
        chk("midrst_no_fall", fall_cnt == 0, 1'b1);
        chk("midrst_dout_after", dout, 1'b0);

        // Randomized runs with occasional asynchronous reset
        for (int n = 0; n < 1200; n++) begin
            din = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 8);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            tick(hold);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
